matrix_result_streamer: RTL and testbench

- Sits downstream of the convolution unit and consumes its packed result bus: out_m, out_n, 400-bit matrices_out and valid.
- On start, captures one result matrix and streams it out one 8-bit element per beat over a valid/ready handshake.
- Each beat carries row/column indices and end-of-line/last markers.
- Feeds the display/UART output path, which consumes elements serially.

---
 rtl/matrix_result_streamer.sv | 158 +++++++++++++++
 tb/tb_matrix_result_streamer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_streamer.sv
// Captures one packed result matrix on start and streams it one element per valid/ready beat.
// Optional column-major traversal is enabled by defining MATRIX_STREAM_TRANSPOSE_EN.
module matrix_result_streamer #(
    parameter int DIM_MAX = 5,
    parameter int ELEM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        res_m,
    input  logic [2:0]        res_n,
    input  logic [399:0]      res_data,
    input  logic              res_valid,
`ifdef MATRIX_STREAM_TRANSPOSE_EN
    input  logic              transpose,
`endif
    output logic              busy,
    output logic              elem_valid,
    input  logic              elem_ready,
    output logic [ELEM_W-1:0] elem_data,
    output logic [2:0]        elem_row,
    output logic [2:0]        elem_col,
    output logic              elem_eol,
    output logic              elem_last,
    output logic              done,
    output logic              err
);
    localparam int NUM_ELEMS = DIM_MAX * DIM_MAX;
    localparam int BUF_W     = NUM_ELEMS * ELEM_W;
    localparam int IDX_W     = $clog2(NUM_ELEMS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [2:0]        row_reg, row_next;
    logic [2:0]        col_reg, col_next;
    logic [2:0]        m_reg, n_reg;
    logic              err_reg, err_next;
    logic              capture;
    logic              col_major;
    logic [ELEM_W-1:0] buf_reg   [NUM_ELEMS];
    logic [ELEM_W-1:0] res_elems [NUM_ELEMS];
    logic [IDX_W-1:0]  idx;
    logic              start_legal;
    logic              row_end, col_end;
    logic              unused_hi;

    // Only the low DIM_MAX*DIM_MAX elements of the wide bus carry data.
    assign unused_hi = ^res_data[399:BUF_W];

    for (genvar gi = 0; gi < NUM_ELEMS; gi++) begin : g_unpack
        assign res_elems[gi] = res_data[gi*ELEM_W +: ELEM_W];
    end

`ifdef MATRIX_STREAM_TRANSPOSE_EN
    logic tr_reg;
    always_ff @(posedge clk) begin
        if (!reset)
            tr_reg <= 1'b0;
        else if (capture)
            tr_reg <= transpose;
    end
    assign col_major = tr_reg;
`else
    assign col_major = 1'b0;
`endif

    assign start_legal = res_valid && (res_m != 3'd0) && (res_m <= 3'(DIM_MAX))
                                   && (res_n != 3'd0) && (res_n <= 3'(DIM_MAX));
    assign row_end = (row_reg == m_reg - 3'd1);
    assign col_end = (col_reg == n_reg - 3'd1);

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        err_next   = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (start_legal) begin
                        capture    = 1'b1;
                        state_next = SEND;
                        row_next   = 3'd0;
                        col_next   = 3'd0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            SEND: begin
                if (elem_ready) begin
                    if (row_end && col_end) begin
                        state_next = DONE;
                        row_next   = 3'd0;
                        col_next   = 3'd0;
                    end else if (col_major) begin
                        if (row_end) begin
                            row_next = 3'd0;
                            col_next = col_reg + 3'd1;
                        end else begin
                            row_next = row_reg + 3'd1;
                        end
                    end else begin
                        if (col_end) begin
                            col_next = 3'd0;
                            row_next = row_reg + 3'd1;
                        end else begin
                            col_next = col_reg + 3'd1;
                        end
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            row_reg   <= 3'd0;
            col_reg   <= 3'd0;
            m_reg     <= 3'd0;
            n_reg     <= 3'd0;
            err_reg   <= 1'b0;
            for (int i = 0; i < NUM_ELEMS; i++)
                buf_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            err_reg   <= err_next;
            if (capture) begin
                m_reg <= res_m;
                n_reg <= res_n;
                for (int i = 0; i < NUM_ELEMS; i++)
                    buf_reg[i] <= res_elems[i];
            end
        end
    end

    // Beat fields depend only on registered state, so backpressure cannot glitch them.
    assign idx        = IDX_W'(row_reg) * IDX_W'(DIM_MAX) + IDX_W'(col_reg);
    assign busy       = (state_reg != IDLE);
    assign elem_valid = (state_reg == SEND);
    assign done       = (state_reg == DONE);
    assign err        = err_reg;
    assign elem_row   = row_reg;
    assign elem_col   = col_reg;
    assign elem_data  = elem_valid ? buf_reg[idx] : '0;
    assign elem_eol   = elem_valid && (col_major ? row_end : col_end);
    assign elem_last  = elem_valid && row_end && col_end;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench for matrix_result_streamer: vector table, hand corner cases and random streams
// checked against a traversal-order model of the packed result matrix.
module tb_matrix_result_streamer;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   res_m = 3'd0;
    logic [2:0]   res_n = 3'd0;
    logic [399:0] res_data = '0;
    logic         res_valid = 1'b0;
    logic         elem_ready = 1'b0;
`ifdef MATRIX_STREAM_TRANSPOSE_EN
    logic         transpose = 1'b0;
`endif
    logic         busy, elem_valid, elem_eol, elem_last, done, err;
    logic [7:0]   elem_data;
    logic [2:0]   elem_row, elem_col;

    matrix_result_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .res_m      (res_m),
        .res_n      (res_n),
        .res_data   (res_data),
        .res_valid  (res_valid),
`ifdef MATRIX_STREAM_TRANSPOSE_EN
        .transpose  (transpose),
`endif
        .busy       (busy),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_data  (elem_data),
        .elem_row   (elem_row),
        .elem_col   (elem_col),
        .elem_eol   (elem_eol),
        .elem_last  (elem_last),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [2:0] row;
        logic [2:0] col;
        logic       eol;
        logic       last;
    } beat_t;

    typedef struct {
        logic       v;
        logic [2:0] m;
        logic [2:0] n;
        logic       legal;
    } vec_t;

    int    tests = 0;
    int    fails = 0;
    beat_t exp_q[$];
    vec_t  vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [399:0] rand_bus();
        logic [415:0] t;
        for (int i = 0; i < 13; i++)
            t[i*32 +: 32] = $urandom();
        return t[399:0];
    endfunction

    // Elements 1,2,3... in row-major order, placed at the fixed stride of 5 per row.
    function automatic logic [399:0] seq_bus(input int m, input int n);
        logic [399:0] b = '0;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++)
                b[(r*5+c)*8 +: 8] = 8'(r*n + c + 1);
        return b;
    endfunction

    task automatic build_exp(input int m, input int n, input logic [399:0] d, input logic tr);
        exp_q.delete();
        for (int k = 0; k < m*n; k++) begin
            int    r, c;
            beat_t b;
            if (tr) begin c = k / m; r = k % m; end
            else    begin r = k / n; c = k % n; end
            b.data = d[(r*5+c)*8 +: 8];
            b.row  = 3'(r);
            b.col  = 3'(c);
            b.eol  = tr ? (r == m-1) : (c == n-1);
            b.last = (k == m*n-1);
            exp_q.push_back(b);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, elem_valid, 0);
        chk({tag, "_data"}, elem_data, 0);
        chk({tag, "_row"}, elem_row, 0);
        chk({tag, "_col"}, elem_col, 0);
        chk({tag, "_eol"}, elem_eol, 0);
        chk({tag, "_last"}, elem_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Called at a negedge; returns at the negedge of cycle t+1 after the start edge.
    task automatic do_start(input logic v, input logic [2:0] m, input logic [2:0] n,
                            input logic [399:0] d, input logic tr, input logic legal);
        res_valid = v;
        res_m     = m;
        res_n     = n;
        res_data  = d;
`ifdef MATRIX_STREAM_TRANSPOSE_EN
        transpose = tr;
`else
        if (tr) $display("transpose request ignored in this build");
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_err", err, !legal);
        chk("start_busy", busy, legal);
        chk("start_valid", elem_valid, legal);
        chk("start_done", done, 0);
        if (!legal) begin
            @(negedge clk);
            chk("err_pulse_len", err, 0);
            chk("rej_busy", busy, 0);
            chk("rej_done", done, 0);
        end
    endtask

    // mode 0: ready always high, 1: ready on every third cycle, 2: random ready.
    task automatic run_stream(input int m, input int n, input logic [399:0] d, input logic tr,
                              input int mode, input logic perturb);
        int   k   = 0;
        int   cyc = 0;
        logic r;
        build_exp(m, n, d, tr);
        while (k < m*n) begin
            if (cyc > 1000) begin
                chk("stream_timeout", 1, 0);
                start = 1'b0;
                return;
            end
            chk("beat_valid", elem_valid, 1);
            if (!elem_valid) begin
                start = 1'b0;
                return;
            end
            chk("beat_busy", busy, 1);
            chk("beat_err", err, 0);
            chk("beat_done", done, 0);
            chk("beat_data", elem_data, exp_q[k].data);
            chk("beat_row", elem_row, exp_q[k].row);
            chk("beat_col", elem_col, exp_q[k].col);
            chk("beat_eol", elem_eol, exp_q[k].eol);
            chk("beat_last", elem_last, exp_q[k].last);
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            elem_ready = r;
            if (perturb && cyc == 1) begin
                start     = 1'b1;
                res_data  = ~res_data;
                res_m     = 3'd1;
                res_n     = 3'd1;
                res_valid = 1'b1;
            end
            if (perturb && cyc == 3) start = 1'b0;
            if (r) k++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_valid", elem_valid, 0);
        if (mode == 0) chk("send_cycles", cyc, m*n);
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", elem_valid, 0);
        chk("idle_err", err, 0);
    endtask

    initial begin
        logic [399:0] d;
        vt[0] = '{1'b1, 3'd2, 3'd3, 1'b1};
        vt[1] = '{1'b0, 3'd2, 3'd3, 1'b0};
        vt[2] = '{1'b1, 3'd0, 3'd3, 1'b0};
        vt[3] = '{1'b1, 3'd3, 3'd6, 1'b0};
        vt[4] = '{1'b1, 3'd1, 3'd1, 1'b1};
        vt[5] = '{1'b1, 3'd5, 3'd5, 1'b1};
        vt[6] = '{1'b1, 3'd6, 3'd1, 1'b0};
        vt[7] = '{1'b1, 3'd5, 3'd0, 1'b0};
        vt[8] = '{1'b1, 3'd4, 3'd2, 1'b1};
        vt[9] = '{1'b1, 3'd7, 3'd7, 1'b0};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        // 2x3 with elements 1..6, ready held high
        elem_ready = 1'b1;
        do_start(1'b1, 3'd2, 3'd3, seq_bus(2, 3), 1'b0, 1'b1);
        chk("first_elem", elem_data, 8'd1);
        run_stream(2, 3, seq_bus(2, 3), 1'b0, 0, 1'b0);

        // back-to-back start right after DONE: 3x3 with backpressure and mid-stream noise
        do_start(1'b1, 3'd3, 3'd3, rand_bus(), 1'b0, 1'b1);
        run_stream(3, 3, dut.res_data, 1'b0, 1, 1'b1);

        // 1x1 minimum case
        d = '0;
        d[7:0] = 8'hAB;
        elem_ready = 1'b1;
        do_start(1'b1, 3'd1, 3'd1, d, 1'b0, 1'b1);
        run_stream(1, 1, d, 1'b0, 0, 1'b0);

        // vector table: legality of start and full stream on legal entries
        foreach (vt[i]) begin
            d = rand_bus();
            do_start(vt[i].v, vt[i].m, vt[i].n, d, 1'b0, vt[i].legal);
            if (vt[i].legal) run_stream(int'(vt[i].m), int'(vt[i].n), d, 1'b0, 2, 1'b0);
            $display("vector %0d: v=%0d m=%0d n=%0d legal=%0d", i, vt[i].v, vt[i].m, vt[i].n, vt[i].legal);
        end

        // reset during the 4th beat of a 5x5 stream
        d = rand_bus();
        elem_ready = 1'b1;
        do_start(1'b1, 3'd5, 3'd5, d, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("pre_abort_col", elem_col, 3);
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("abort");
        reset = 1'b1;
        @(negedge clk);
        chk("abort_no_done", done, 0);
        do_start(1'b1, 3'd5, 3'd5, d, 1'b0, 1'b1);
        run_stream(5, 5, d, 1'b0, 0, 1'b0);

`ifdef MATRIX_STREAM_TRANSPOSE_EN
        elem_ready = 1'b1;
        do_start(1'b1, 3'd2, 3'd3, seq_bus(2, 3), 1'b1, 1'b1);
        run_stream(2, 3, seq_bus(2, 3), 1'b1, 0, 1'b1);
`endif

        // random starts, legal and illegal, with random backpressure
        for (int i = 0; i < 12; i++) begin
            logic       v, tr, legal;
            logic [2:0] m, n;
            v  = ($urandom_range(0, 3) != 0);
            m  = 3'($urandom_range(0, 7));
            n  = 3'($urandom_range(0, 7));
`ifdef MATRIX_STREAM_TRANSPOSE_EN
            tr = 1'($urandom_range(0, 1));
`else
            tr = 1'b0;
`endif
            legal = v && m >= 1 && m <= 5 && n >= 1 && n <= 5;
            d = rand_bus();
            do_start(v, m, n, d, tr, legal);
            if (legal) run_stream(int'(m), int'(n), d, tr, 2, 1'b0);
            $display("random %0d: v=%0d m=%0d n=%0d tr=%0d legal=%0d", i, v, m, n, tr, legal);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
